pam_m_encode: RTL and testbench

//  Multi-lane PAM-M symbol mapper (M = 2**BITS_PER_SYM) for the FEC test datapath; successor to the fixed PAM-4 mapper.

---
 rtl/pam_pkg.sv | 24 ++
 rtl/pam_precode_lane.sv | 23 ++
 rtl/pam_m_encode.sv | 106 ++++++++++
 tb/tb_pam_m_encode.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pam_pkg.sv
// Shared constants, types and level/label helpers for the PAM-M symbol mapper.
package pam_pkg;

  localparam int unsigned MAX_BITS              = 3;
  localparam int unsigned DEF_BITS_PER_SYM      = 2;
  localparam int unsigned DEF_SIGNAL_RESOLUTION = 8;
  localparam int unsigned DEF_M                 = 1 << DEF_BITS_PER_SYM;

  typedef logic signed [DEF_SIGNAL_RESOLUTION-1:0] sample_t;

  function automatic int unsigned pam_m(input int unsigned bits);
    return 32'(1) << bits;
  endfunction

  // Narrower labels are zero-extended, so the upper terms drop out.
  function automatic logic [MAX_BITS-1:0] gray2bin(input logic [MAX_BITS-1:0] g);
    return g ^ (g >> 1) ^ (g >> 2);
  endfunction

  function automatic int pam_level(input int p, input int m, input int sep);
    return ((2 * p - (m - 1)) * sep) >>> 1;
  endfunction

endpackage

// File: rtl/pam_precode_lane.sv
// One lane of the S1 chain: optional Gray decode followed by optional mod-M subtract.
module pam_precode_lane
  import pam_pkg::*;
#(
  parameter int unsigned BITS_PER_SYM = 2
) (
  input  logic [BITS_PER_SYM-1:0] sym,
  input  logic                    gray_en,
  input  logic                    precode_en,
  input  logic [BITS_PER_SYM-1:0] p_prev,
  output logic [BITS_PER_SYM-1:0] p_c
);

  logic [MAX_BITS-1:0]     sym_ext;
  logic [BITS_PER_SYM-1:0] k;

  always_comb begin
    sym_ext = MAX_BITS'(sym);
    k       = gray_en ? BITS_PER_SYM'(gray2bin(sym_ext)) : sym;
    p_c     = precode_en ? BITS_PER_SYM'(k - p_prev) : k;
  end

endmodule

// File: rtl/pam_m_encode.sv
// Multi-lane PAM-M mapper: S1 registers precoded indices, S2 registers signed levels.
module pam_m_encode
  import pam_pkg::*;
#(
  parameter int unsigned BITS_PER_SYM      = 2,
  parameter int unsigned LANES             = 4,
  parameter int unsigned SIGNAL_RESOLUTION = 8,
  parameter int unsigned SYMBOL_SEPARATION = 48
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 gray_en,
  input  logic                                 precode_en,
  input  logic [LANES*BITS_PER_SYM-1:0]        symbol_in,
  input  logic                                 symbol_in_valid,
  output logic                                 symbol_in_ready,
  output logic [LANES*SIGNAL_RESOLUTION-1:0]   signal_out,
  output logic                                 signal_out_valid,
  input  logic                                 signal_out_ready
);

  localparam int unsigned B = BITS_PER_SYM;
  localparam int unsigned R = SIGNAL_RESOLUTION;
  localparam int unsigned M = pam_m(B);

  if (B == 0 || B > MAX_BITS) begin : g_bad_bits
    $error("pam_m_encode: BITS_PER_SYM must be 1..3");
  end
  if (SYMBOL_SEPARATION % 2 != 0) begin : g_bad_sep
    $error("pam_m_encode: SYMBOL_SEPARATION must be even");
  end
  if ((M - 1) * SYMBOL_SEPARATION / 2 > (32'(1) << (R - 1)) - 1) begin : g_bad_res
    $error("pam_m_encode: outer level does not fit SIGNAL_RESOLUTION");
  end

  logic               s1_valid;
  logic [LANES*B-1:0] s1_p;
  logic [LANES*B-1:0] p_c;
  logic [B-1:0]       state;
  logic               s1_adv;
  logic               s2_adv;
  logic               accept;
  logic [LANES*R-1:0] level_c;

  // Lane chain: lane 0 subtracts the carried state, later lanes the previous lane.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [B-1:0] prev;
    logic [B-1:0] lane_p;
    if (i == 0) begin : g_first
      assign prev = state;
    end else begin : g_next
      assign prev = g_lane[i-1].lane_p;
    end
    pam_precode_lane #(.BITS_PER_SYM(B)) u_lane (
      .sym        (symbol_in[i*B +: B]),
      .gray_en    (gray_en),
      .precode_en (precode_en),
      .p_prev     (prev),
      .p_c        (lane_p)
    );
    assign p_c[i*B +: B] = lane_p;
  end

  always_comb begin
    s2_adv          = !signal_out_valid || signal_out_ready;
    s1_adv          = s1_valid && s2_adv;
    symbol_in_ready = !rst && (!s1_valid || s1_adv);
    accept          = symbol_in_valid && symbol_in_ready;
  end

  // Index to signed level, truncated to the sample width.
  always_comb begin
    level_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      level_c[i*R +: R] = R'(pam_level(int'(s1_p[i*B +: B]), int'(M),
                                       int'(SYMBOL_SEPARATION)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid         <= 1'b0;
      s1_p             <= '0;
      state            <= '0;
      signal_out_valid <= 1'b0;
      signal_out       <= '0;
    end else begin
      if (symbol_in_ready) begin
        s1_valid <= symbol_in_valid;
      end
      if (accept) begin
        s1_p <= p_c;
        if (precode_en) begin
          state <= p_c[(LANES-1)*B +: B];
        end
      end
      if (s2_adv) begin
        signal_out_valid <= s1_valid;
        if (s1_valid) begin
          signal_out <= level_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_pam_m_encode.sv
// Scoreboard bench for pam_m_encode: directed vectors, random backpressure, reset, other M.
module tb_pam_m_encode;
  import pam_pkg::*;

  localparam int B    = 2;
  localparam int LN   = 4;
  localparam int R    = 8;
  localparam int SEP  = 48;
  localparam int M    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        gray_en, precode_en;
  logic [7:0]  symbol_in;
  logic        symbol_in_valid, symbol_in_ready;
  logic [31:0] signal_out;
  logic        signal_out_valid, signal_out_ready;

  logic [11:0] p8_sym;
  logic        p8_valid, p8_ready, p8_out_valid;
  logic [31:0] p8_out;
  logic [1:0]  p2_sym;
  logic        p2_valid, p2_ready, p2_out_valid;
  logic [15:0] p2_out;

  always #5 clk = ~clk;

  pam_m_encode #(.BITS_PER_SYM(2), .LANES(4), .SIGNAL_RESOLUTION(8), .SYMBOL_SEPARATION(48)) dut (
    .clk(clk), .rst(rst), .gray_en(gray_en), .precode_en(precode_en),
    .symbol_in(symbol_in), .symbol_in_valid(symbol_in_valid), .symbol_in_ready(symbol_in_ready),
    .signal_out(signal_out), .signal_out_valid(signal_out_valid), .signal_out_ready(signal_out_ready));

  pam_m_encode #(.BITS_PER_SYM(3), .LANES(4), .SIGNAL_RESOLUTION(8), .SYMBOL_SEPARATION(16)) u_p8 (
    .clk(clk), .rst(rst), .gray_en(1'b0), .precode_en(1'b0),
    .symbol_in(p8_sym), .symbol_in_valid(p8_valid), .symbol_in_ready(p8_ready),
    .signal_out(p8_out), .signal_out_valid(p8_out_valid), .signal_out_ready(1'b1));

  pam_m_encode #(.BITS_PER_SYM(1), .LANES(2), .SIGNAL_RESOLUTION(8), .SYMBOL_SEPARATION(2)) u_p2 (
    .clk(clk), .rst(rst), .gray_en(1'b0), .precode_en(1'b0),
    .symbol_in(p2_sym), .symbol_in_valid(p2_valid), .symbol_in_ready(p2_ready),
    .signal_out(p2_out), .signal_out_valid(p2_out_valid), .signal_out_ready(1'b1));

  int          errors = 0;
  int          checks = 0;
  int          mstate = 0;
  logic [31:0] exp_q[$];
  bit          acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Reference mapper: Gray decode MSB-first, mod-M difference precoder, exact level.
  task automatic model_beat(input logic [7:0] sym, input bit g, input bit pre,
                            output logic [31:0] e);
    int prev;
    prev = mstate;
    e = '0;
    for (int i = 0; i < LN; i++) begin
      logic [1:0] s;
      int k, p;
      bit carry, bv;
      s = sym[i*B +: B];
      k = 0;
      carry = 1'b0;
      for (int j = B - 1; j >= 0; j--) begin
        bv = g ? (s[j] ^ carry) : s[j];
        carry = bv;
        if (bv) k += (1 << j);
      end
      p = pre ? ((k - prev + M) % M) : k;
      prev = p;
      e[i*R +: R] = 8'((2 * p - (M - 1)) * SEP / 2);
    end
    if (pre) mstate = prev;
  endtask

  // Evaluate the upcoming posedge handshakes, then advance to the next negedge.
  task automatic tick();
    logic [31:0] e;
    #1;
    acc = 1'b0;
    if (rst) begin
      mstate = 0;
      exp_q.delete();
    end else begin
      if (signal_out_valid && signal_out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", 32'(signal_out_valid), 32'd0);
        else check("sb_data", signal_out, exp_q.pop_front());
      end
      if (symbol_in_valid && symbol_in_ready) begin
        model_beat(symbol_in, gray_en, precode_en, e);
        exp_q.push_back(e);
        acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int sent;
    rst = 1'b1; gray_en = 1'b0; precode_en = 1'b0; symbol_in = '0;
    symbol_in_valid = 1'b0; signal_out_ready = 1'b0;
    p8_sym = '0; p8_valid = 1'b0; p2_sym = '0; p2_valid = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("rst_in_ready", 32'(symbol_in_ready), 32'd0);
    check("rst_out_valid", 32'(signal_out_valid), 32'd0);
    check("rst_out_data", signal_out, 32'd0);

    // Plain binary labels with two-cycle latency.
    rst = 1'b0; signal_out_ready = 1'b1;
    symbol_in = 8'he4; symbol_in_valid = 1'b1;
    tick();
    symbol_in_valid = 1'b0;
    check("t1_valid_early", 32'(signal_out_valid), 32'd0);
    tick();
    check("t1_valid", 32'(signal_out_valid), 32'd1);
    check("t1_data", signal_out, pack4(-72, -24, 24, 72));
    tick();

    // Gray labels 00,01,11,10 map to the same ascending levels.
    gray_en = 1'b1; symbol_in = 8'hb4; symbol_in_valid = 1'b1;
    tick();
    symbol_in_valid = 1'b0;
    tick();
    check("t2_data", signal_out, pack4(-72, -24, 24, 72));
    tick();

    // Back-to-back precoded beats carry state across the beat boundary.
    gray_en = 1'b0; precode_en = 1'b1;
    symbol_in = 8'h25; symbol_in_valid = 1'b1;
    tick();
    symbol_in = 8'h03;
    tick();
    symbol_in_valid = 1'b0;
    check("t3_beat1", signal_out, pack4(-24, -72, 24, 24));
    tick();
    check("t3_beat2", signal_out, pack4(-24, 72, -24, 72));
    tick();

    // Random stream under random backpressure and per-beat mode changes.
    sent = 0;
    for (int cyc = 0; cyc < 400 && (sent < 20 || exp_q.size() != 0); cyc++) begin
      if (!symbol_in_valid && sent < 20 && $urandom_range(3) != 0) begin
        symbol_in_valid = 1'b1;
        symbol_in  = 8'($urandom);
        gray_en    = 1'($urandom_range(1));
        precode_en = 1'($urandom_range(1));
      end
      signal_out_ready = 1'($urandom_range(1));
      tick();
      if (acc) begin
        sent++;
        symbol_in_valid = 1'b0;
      end
    end
    check("stream_sent", 32'(sent), 32'd20);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Stall downstream: input ready must drop once both stages are full.
    signal_out_ready = 1'b1; symbol_in_valid = 1'b0;
    tick();
    tick();
    signal_out_ready = 1'b0; gray_en = 1'b0; precode_en = 1'b1;
    symbol_in = 8'h03; symbol_in_valid = 1'b1;
    tick();
    tick();
    check("bp_ready_low", 32'(symbol_in_ready), 32'd0);
    check("bp_out_valid", 32'(signal_out_valid), 32'd1);
    tick();
    check("bp_ready_held", 32'(symbol_in_ready), 32'd0);

    // Reset with two beats in flight discards them and clears the precoder.
    rst = 1'b1; symbol_in_valid = 1'b0;
    #1 check("rst_mid_ready", 32'(symbol_in_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("rst_mid_valid", 32'(signal_out_valid), 32'd0);
    check("rst_mid_data", signal_out, 32'd0);
    signal_out_ready = 1'b1; precode_en = 1'b1;
    symbol_in = 8'h25; symbol_in_valid = 1'b1;
    tick();
    symbol_in_valid = 1'b0;
    tick();
    check("rst_pre_data", signal_out, pack4(-24, -72, 24, 24));
    tick();

    // PAM8 and PAM2 level tables.
    p8_sym = {3'd0, 3'd4, 3'd7, 3'd0}; p8_valid = 1'b1;
    p2_sym = 2'b10; p2_valid = 1'b1;
    tick();
    p8_valid = 1'b0; p2_valid = 1'b0;
    tick();
    check("p8_valid", 32'(p8_out_valid), 32'd1);
    check("p8_data", p8_out, {8'hc8, 8'h08, 8'h38, 8'hc8});
    check("p2_valid", 32'(p2_out_valid), 32'd1);
    check("p2_data", 32'(p2_out), 32'h0000_01ff);
    check("p8_lane2", 32'(sample_t'(p8_out[23:16])), 32'(8'sd8));
    tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
